score_seg7_display: RTL and testbench

//  Parametrised successor to the fixed per-nibble HEX score drivers: converts the game score to
//  NUM_DIGITS seven-segment digits in decimal (iterative double-dabble) or raw hex mode.

---
 rtl/score_disp_pkg.sv | 21 ++
 rtl/seg7_encode.sv | 32 +++
 rtl/score_seg7_display.sv | 169 ++++++++++++++++
 tb/tb_score_seg7_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the seven-segment score display.
// Segment codes are active-low with the decimal point held off.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_NINE  = 8'h90;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    // Number of BCD digits needed to hold any w-bit unsigned value.
    function automatic int bcd_digits(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low seven-segment code; bit 7 (DP) is always 1.
module seg7_encode
    import score_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_seg7_display.sv
// Converts a score to NUM_DIGITS seven-segment digits (double-dabble decimal or raw hex),
// with leading-zero blanking, decimal saturation, a pending request slot and a high-score register.
module score_seg7_display
    import score_disp_pkg::*;
#(
    parameter int SCORE_W       = 20,
    parameter int NUM_DIGITS    = 6,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    score_valid,
    input  logic                    dec_mode,
    input  logic                    clear_high,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [SCORE_W-1:0]      high_score,
    output logic                    new_high
);

    localparam int BCD_DIGITS = bcd_digits(SCORE_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int PAD_W      = BCD_W + DISP_W + SCORE_W;
    localparam int CNT_W      = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_W - 1);

    function automatic logic [8*NUM_DIGITS-1:0] reset_hex();
        logic [8*NUM_DIGITS-1:0] v;
        for (int i = 0; i < NUM_DIGITS; i++)
            v[8*i +: 8] = (i == 0 || !BLANK_LEADING) ? SEG_ZERO : SEG_BLANK;
        return v;
    endfunction

    localparam logic [8*NUM_DIGITS-1:0] RESET_HEX = reset_hex();

    state_t               state;
    logic [SCORE_W-1:0]   value;
    logic [SCORE_W-1:0]   bin;
    logic [BCD_W-1:0]     bcd;
    logic [CNT_W-1:0]     cnt;
    logic                 mode;
    logic                 hex_wait;
    logic                 beats_high;
    logic                 pend_valid;
    logic [SCORE_W-1:0]   pend_score;
    logic                 pend_mode;

    logic                 req_go;
    logic [SCORE_W-1:0]   req_score;
    logic                 req_mode;
    logic [BCD_W-1:0]     bcd_adj;
    logic [PAD_W-1:0]     src_pad;
    logic [DISP_W-1:0]    digits;
    logic                 ovf;
    logic                 sat;
    logic                 lead;
    logic [NUM_DIGITS-1:0] blank;
    logic [8*NUM_DIGITS-1:0] disp;

    // A live request on the IDLE edge is newer than anything parked in the slot.
    assign req_go    = score_valid | pend_valid;
    assign req_score = score_valid ? score : pend_score;
    assign req_mode  = score_valid ? dec_mode : pend_mode;

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++)
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end

    assign src_pad = mode ? PAD_W'(bcd) : PAD_W'(value);
    assign digits  = src_pad[DISP_W-1:0];
    assign ovf     = |(src_pad >> DISP_W);
    assign sat     = mode & ovf;

    always_comb begin
        lead  = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (digits[4*i +: 4] != 4'd0) lead = 1'b0;
            blank[i] = lead & BLANK_LEADING;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [7:0] seg;
        seg7_encode u_enc (
            .nibble (digits[4*g +: 4]),
            .seg    (seg)
        );
        assign disp[8*g +: 8] = sat ? SEG_NINE : (blank[g] ? SEG_BLANK : seg);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            value      <= '0;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            mode       <= 1'b0;
            hex_wait   <= 1'b0;
            beats_high <= 1'b0;
            pend_valid <= 1'b0;
            pend_score <= '0;
            pend_mode  <= 1'b0;
            hex_out    <= RESET_HEX;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            high_score <= '0;
            new_high   <= 1'b0;
        end else begin
            done     <= 1'b0;
            new_high <= 1'b0;
            busy     <= (state != IDLE) | pend_valid;

            if (state != IDLE && score_valid) begin
                pend_valid <= 1'b1;
                pend_score <= score;
                pend_mode  <= dec_mode;
            end

            case (state)
                IDLE: begin
                    if (req_go) begin
                        value      <= req_score;
                        bin        <= req_score;
                        bcd        <= '0;
                        cnt        <= '0;
                        mode       <= req_mode;
                        hex_wait   <= ~req_mode;
                        beats_high <= req_score > high_score;
                        pend_valid <= 1'b0;
                        state      <= req_mode ? LOAD : LATCH;
                    end
                end
                LOAD: state <= SHIFT;
                SHIFT: begin
                    bcd <= {bcd_adj[BCD_W-2:0], bin[SCORE_W-1]};
                    bin <= {bin[SCORE_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_SHIFT) state <= LATCH;
                end
                LATCH: begin
                    // Hex requests idle here one cycle so both modes share the two-edge front end.
                    if (hex_wait) begin
                        hex_wait <= 1'b0;
                    end else begin
                        hex_out  <= disp;
                        overflow <= ovf;
                        done     <= 1'b1;
                        new_high <= beats_high & ~clear_high;
                        if (beats_high) high_score <= value;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (clear_high) high_score <= '0;
        end
    end

endmodule

// File: tb/tb_score_seg7_display.sv
// Directed bench for score_seg7_display: decimal/hex conversion, saturation, blanking,
// pending-slot overwrite, high-score tracking and mid-conversion reset.
module tb_score_seg7_display;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] score;
    logic        score_valid;
    logic        dec_mode;
    logic        clear_high;
    logic [47:0] hex_out;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [19:0] high_score;
    logic        new_high;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_q[$];

    score_seg7_display #(
        .SCORE_W       (20),
        .NUM_DIGITS    (6),
        .BLANK_LEADING (1'b1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .score       (score),
        .score_valid (score_valid),
        .dec_mode    (dec_mode),
        .clear_high  (clear_high),
        .hex_out     (hex_out),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .high_score  (high_score),
        .new_high    (new_high)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [19:0] s, input logic m);
        score       = s;
        dec_mode    = m;
        score_valid = 1'b1;
        step();
        score_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        while (1) begin
            step();
            lat++;
            if (done) break;
            if (lat >= budget) begin
                check_eq({tag, "_timeout"}, done, 1);
                break;
            end
        end
    endtask

    task automatic convert(input string tag, input logic [19:0] s, input logic m,
                           input logic [47:0] exp_hex, input logic exp_ovf,
                           input logic exp_nh, input logic [19:0] exp_high, input int exp_lat);
        int lat;
        exp_q.push_back(exp_hex);
        send(s, m);
        wait_done(tag, 60, lat);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_hex"}, hex_out, exp_q.pop_front());
        check_eq({tag, "_ovf"}, overflow, exp_ovf);
        check_eq({tag, "_newhigh"}, new_high, exp_nh);
        check_eq({tag, "_busy_at_done"}, busy, 1);
        step();
        check_eq({tag, "_high"}, high_score, exp_high);
        check_eq({tag, "_busy_after"}, busy, 0);
        check_eq({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int extra_done;

        Reset = 1'b1; score = '0; score_valid = 1'b0; dec_mode = 1'b0; clear_high = 1'b0;
        repeat (3) step();
        Reset = 1'b0;
        step();

        check_eq("rst_hex", hex_out, 48'hFFFF_FFFF_FFC0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_high", high_score, 0);
        check_eq("rst_newhigh", new_high, 0);

        convert("dec12345", 20'd12345,  1'b1, 48'hFFF9_A4B0_9992, 1'b0, 1'b1, 20'd12345,   22);
        convert("hexABCDE", 20'hABCDE,  1'b0, 48'hFF88_83C6_A186, 1'b0, 1'b1, 20'hABCDE,   2);
        convert("dec1e6",   20'd1000000,1'b1, 48'h9090_9090_9090, 1'b1, 1'b1, 20'd1000000, 22);
        convert("dec7",     20'd7,      1'b1, 48'hFFFF_FFFF_FFF8, 1'b0, 1'b0, 20'd1000000, 22);
        convert("dec999999",20'd999999, 1'b1, 48'h9090_9090_9090, 1'b0, 1'b0, 20'd1000000, 22);
        convert("hexFFFFF", 20'hFFFFF,  1'b0, 48'hFF8E_8E8E_8E8E, 1'b0, 1'b1, 20'hFFFFF,   2);
        convert("dec0",     20'd0,      1'b1, 48'hFFFF_FFFF_FFC0, 1'b0, 1'b0, 20'hFFFFF,   22);

        clear_high = 1'b1;
        step();
        clear_high = 1'b0;
        check_eq("clear_idle_high", high_score, 0);

        // Two requests during one conversion: only the newest survives.
        exp_q.push_back(48'hFFFF_FFFF_FF92);
        exp_q.push_back(48'hFFFF_FFFF_99A4);
        send(20'd5, 1'b1);
        repeat (4) step();
        send(20'd9, 1'b1);
        repeat (2) step();
        send(20'd42, 1'b1);
        wait_done("pend_first", 40, lat);
        check_eq("pend_first_hex", hex_out, exp_q.pop_front());
        check_eq("pend_first_newhigh", new_high, 1);
        step();
        check_eq("pend_first_high", high_score, 5);
        check_eq("pend_busy_gapless", busy, 1);
        wait_done("pend_second", 40, lat);
        check_eq("pend_second_lat", lat, 22);
        check_eq("pend_second_hex", hex_out, exp_q.pop_front());
        check_eq("pend_second_newhigh", new_high, 1);
        step();
        check_eq("pend_second_high", high_score, 42);
        extra_done = 0;
        repeat (30) begin
            step();
            if (done) extra_done++;
        end
        check_eq("pend_no_third", extra_done, 0);

        convert("dec500", 20'd500, 1'b1, 48'hFFFF_FF92_C0C0, 1'b0, 1'b1, 20'd500, 22);
        convert("dec300", 20'd300, 1'b1, 48'hFFFF_FFB0_C0C0, 1'b0, 1'b0, 20'd500, 22);

        // clear_high lands on the same edge as the 900 update.
        send(20'd900, 1'b1);
        repeat (21) step();
        clear_high = 1'b1;
        step();
        clear_high = 1'b0;
        check_eq("clr_same_edge_done", done, 1);
        check_eq("clr_same_edge_hex", hex_out, 48'hFFFF_FF90_C0C0);
        check_eq("clr_same_edge_high", high_score, 0);

        convert("sat_before_rst", 20'd1000000, 1'b1, 48'h9090_9090_9090, 1'b1, 1'b1, 20'd1000000, 22);

        // Reset in the middle of SHIFT with a request parked in the slot.
        send(20'd12345, 1'b1);
        repeat (5) step();
        send(20'd77, 1'b0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("midrst_hex", hex_out, 48'hFFFF_FFFF_FFC0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_ovf", overflow, 0);
        check_eq("midrst_high", high_score, 0);
        check_eq("midrst_newhigh", new_high, 0);
        extra_done = 0;
        repeat (40) begin
            step();
            if (done || busy) extra_done++;
        end
        check_eq("midrst_quiet", extra_done, 0);

        convert("post_rst_hex7", 20'h7, 1'b0, 48'hFFFF_FFFF_FFF8, 1'b0, 1'b1, 20'h7, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
